// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with 2-entry {pc, instr} buffer
//
// Issues one outstanding word read at a time to instruction memory and queues
// returned words in order toward decode. A redirect flushes queued words and
// marks any in-flight response for discard.

module instr_fetch_unit #(
  parameter int                   WORD_SIZE  = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = 32'h0000_0040,
  parameter int                   FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [WORD_SIZE-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic                 imem_rvalid,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 redirect_valid,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic [WORD_SIZE-1:0] instr_pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Buffer is exactly two entries; pointers are single bits.
  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  state_t               state;
  logic [WORD_SIZE-1:0] fetch_pc;
  logic [WORD_SIZE-1:0] tag_pc;
  logic                 drop;

  logic [WORD_SIZE-1:0] fifo_pc    [2];
  logic [WORD_SIZE-1:0] fifo_instr [2];
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic [1:0]           count;

  logic                 push;
  logic                 pop;
  logic [1:0]           count_after;
  logic                 credit_after;

  assign imem_addr      = fetch_pc;
  assign instr_valid    = (count != 2'd0);
  assign instruction    = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc       = instr_valid ? fifo_pc[rd_ptr] : '0;
  assign instr_pc_plus4 = instr_pc + WORD_SIZE'(4);

  // Occupancy after this cycle's push/pop; credit is evaluated with no read outstanding
  always_comb begin
    push         = (state == S_WAIT) && imem_rvalid && !drop && !redirect_valid;
    pop          = instr_valid && instr_ready && !redirect_valid;
    count_after  = count;
    if (push && !pop) begin
      count_after = count + 2'd1;
    end else if (!push && pop) begin
      count_after = count - 2'd1;
    end
    credit_after = (count_after < DEPTH);
  end

  // Fetch FSM: request sequencing, PC advance and redirect/drop handling
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      imem_req <= 1'b0;
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      drop     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[WORD_SIZE-1:2], 2'b00};
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            // The read already left; its response must be thrown away
            tag_pc   <= fetch_pc;
            drop     <= 1'b1;
            state    <= S_WAIT;
            imem_req <= 1'b0;
          end else begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop     <= 1'b0;
            state    <= S_REQ;
            imem_req <= 1'b1;
          end else begin
            drop     <= 1'b1;
            state    <= S_WAIT;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= S_REQ;
          imem_req <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          if (credit_after) begin
            state    <= S_REQ;
            imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ack) begin
            tag_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + WORD_SIZE'(4);
            state    <= S_WAIT;
            imem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (credit_after) begin
              state    <= S_REQ;
              imem_req <= 1'b1;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // In-order fetch buffer; redirect empties it and overrides any pop
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= tag_pc;
        fifo_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_after;
    end
  end

`ifndef SYNTHESIS
  // Read data may only return while a read is outstanding
  always @(posedge clk) begin
    if (reset_n && imem_rvalid) begin
      assert (state == S_WAIT);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed vector bench for instr_fetch_unit

module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  int checks = 0;
  int errors = 0;
  bit auto_mem = 1'b1;
  logic [31:0] dq_pc[$];
  logic [31:0] dq_ins[$];

  typedef struct {
    logic        ack;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_plus4;
  } vec_t;

  vec_t vecs[7];

  instr_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: record handshakes before the edge, then the memory model
  // answers an accepted request with rvalid on the following cycle.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = imem_req && imem_ack;
    a  = imem_addr;
    if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
      dq_pc.push_back(instr_pc);
      dq_ins.push_back(instruction);
    end
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rvalid = hs;
      imem_rdata  = hs ? mk(a) : 32'h0;
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    auto_mem       = 1'b1;
    tick();
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    reset_n     = 1'b1;
    dq_pc.delete();
    dq_ins.delete();
  endtask

  function automatic logic [31:0] dq_at(input int i, input bit want_pc);
    if (dq_pc.size() <= i) return 32'hFFFF_FFFF;
    return want_pc ? dq_pc[i] : dq_ins[i];
  endfunction

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  32'h0,         32'h4};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h44, 1'b0, 32'h0,  32'h0,         32'h4};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h44, 1'b1, 32'h40, 32'hC0DE_0040, 32'h44};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h48, 1'b0, 32'h0,  32'h0,         32'h4};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h48, 1'b1, 32'h44, 32'hC0DE_0044, 32'h48};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h4C, 1'b0, 32'h0,  32'h0,         32'h4};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h4C, 1'b1, 32'h48, 32'hC0DE_0048, 32'h4C};

    reset_n = 1'b0; imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_req",   32'(imem_req),    32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_addr",  imem_addr,        32'h40);
    check("rst_instr", instruction,      32'h0);
    check("rst_pc",    instr_pc,         32'h0);

    // Streaming fetch, one word every two cycles
    for (int i = 0; i < 7; i++) begin
      imem_ack    = vecs[i].ack;
      instr_ready = vecs[i].ready;
      tick();
      check($sformatf("t1_r%0d_req", i),   32'(imem_req),    32'(vecs[i].exp_req));
      check($sformatf("t1_r%0d_addr", i),  imem_addr,        vecs[i].exp_addr);
      check($sformatf("t1_r%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      check($sformatf("t1_r%0d_pc", i),    instr_pc,         vecs[i].exp_pc);
      check($sformatf("t1_r%0d_instr", i), instruction,      vecs[i].exp_instr);
      check($sformatf("t1_r%0d_plus4", i), instr_pc_plus4,   vecs[i].exp_plus4);
    end

    // Back-pressure fills the buffer, then drains in order
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 5) check($sformatf("t2_stall%0d_req", i), 32'(imem_req), 32'h0);
    end
    check("t2_hold_valid", 32'(instr_valid), 32'h1);
    check("t2_hold_pc",    instr_pc,         32'h40);
    check("t2_hold_instr", instruction,      32'hC0DE_0040);
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("t2_count_ge3", 32'(dq_pc.size() >= 3), 32'h1);
    check("t2_d0_pc",  dq_at(0, 1'b1), 32'h40);
    check("t2_d1_pc",  dq_at(1, 1'b1), 32'h44);
    check("t2_d2_pc",  dq_at(2, 1'b1), 32'h48);
    check("t2_d1_ins", dq_at(1, 1'b0), 32'hC0DE_0044);

    // Request held while ack is low
    do_reset();
    instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t3_hold%0d_req", i),  32'(imem_req), 32'h1);
      check($sformatf("t3_hold%0d_addr", i), imem_addr,     32'h40);
    end
    imem_ack = 1'b1;
    tick();
    check("t3_ack_addr", imem_addr,     32'h44);
    check("t3_ack_req",  32'(imem_req), 32'h0);

    // Redirect in WAIT: stale response dropped
    do_reset();
    auto_mem = 1'b0; instr_ready = 1'b1; imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1003;
    tick();
    redirect_valid = 1'b0;
    check("t4_redir_addr",  imem_addr,        32'h1000);
    check("t4_redir_valid", 32'(instr_valid), 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("t4_stale_valid", 32'(instr_valid), 32'h0);
    check("t4_stale_req",   32'(imem_req),    32'h1);
    check("t4_stale_addr",  imem_addr,        32'h1000);
    auto_mem = 1'b1; imem_ack = 1'b1;
    tick();
    check("t4_wait_valid", 32'(instr_valid), 32'h0);
    tick();
    check("t4_new_valid", 32'(instr_valid), 32'h1);
    check("t4_new_pc",    instr_pc,         32'h1000);
    check("t4_new_instr", instruction,      32'hC0DE_1000);

    // Redirect with simultaneous rvalid and pop, buffer occupied
    do_reset();
    auto_mem = 1'b0; imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_0040;
    tick();
    imem_rvalid = 1'b0; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("t5a_pre_valid", 32'(instr_valid), 32'h1);
    check("t5a_pre_pc",    instr_pc,         32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    check("t5a_valid", 32'(instr_valid), 32'h0);
    check("t5a_req",   32'(imem_req),    32'h1);
    check("t5a_addr",  imem_addr,        32'h2000);
    check("t5a_npop",  32'(dq_pc.size()), 32'h0);

    // Redirect with full buffer and ready: pop discarded
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t5b_full_pc", instr_pc, 32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000; instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t5b_valid", 32'(instr_valid),  32'h0);
    check("t5b_req",   32'(imem_req),     32'h1);
    check("t5b_addr",  imem_addr,         32'h3000);
    check("t5b_npop",  32'(dq_pc.size()), 32'h0);
    tick();
    tick();
    check("t5b_next_pc", instr_pc, 32'h3000);

    // PC wrap and reset in WAIT
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("t6_top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    tick();
    check("t6_wrap_addr", imem_addr, 32'h0);
    tick();
    check("t6_wrap_valid", 32'(instr_valid), 32'h1);
    check("t6_wrap_pc",    instr_pc,         32'hFFFF_FFFC);
    check("t6_wrap_plus4", instr_pc_plus4,   32'h0);
    check("t6_wrap_instr", instruction,      32'hC0DE_FFFC);
    tick();
    imem_ack = 1'b0; reset_n = 1'b0;
    tick();
    check("t6_rst_req",   32'(imem_req),    32'h0);
    check("t6_rst_valid", 32'(instr_valid), 32'h0);
    check("t6_rst_addr",  imem_addr,        32'h40);
    check("t6_rst_instr", instruction,      32'h0);
    check("t6_rst_pc",    instr_pc,         32'h0);
    reset_n = 1'b1;
    tick();
    check("t6_after_req", 32'(imem_req), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
